// File: rtl/multiword_add_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : multiword_add_seq_pkg
// Purpose  : Shared types and helpers for the sequential multi-precision
//            adder/subtractor: controller state encoding, default slice
//            width, and slice-count / counter-width helpers.
// Revision : 1.0 - initial release
// ============================================================================
package multiword_add_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int SLICE_DEFAULT = 4;

    // Number of slice passes needed to cover a full operand.
    function automatic int num_slices(input int width, input int slice);
        return width / slice;
    endfunction

    // Slice counter width; at least one bit so N=1 still has a legal counter.
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage : multiword_add_seq_pkg
`default_nettype wire

// File: rtl/multiword_add_seq_adder_slice.sv
`default_nettype none
// ============================================================================
// Module   : multiword_add_seq_adder_slice
// Purpose  : Combinational SLICE-bit ripple-carry adder shared by every pass
//            of the sequential multi-word adder.
// Ports    : a, b  - slice operands (SLICE bits)
//            cin   - carry into bit 0
//            s     - slice sum (SLICE bits)
//            cout  - carry out of the top bit
// Revision : 1.0 - initial release
// ============================================================================
module multiword_add_seq_adder_slice #(
    parameter int SLICE = 4
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             cin,
    output logic [SLICE-1:0] s,
    output logic             cout
);

    logic [SLICE:0] w_carry;

    assign w_carry[0] = cin;

    for (genvar i = 0; i < SLICE; i++) begin : g_bit
        assign s[i]           = a[i] ^ b[i] ^ w_carry[i];
        assign w_carry[i + 1] = (a[i] & b[i]) | (w_carry[i] & (a[i] ^ b[i]));
    end

    assign cout = w_carry[SLICE];

endmodule : multiword_add_seq_adder_slice
`default_nettype wire

// File: rtl/multiword_add_seq.sv
`default_nettype none
// ============================================================================
// Module   : multiword_add_seq
// Purpose  : Sequential multi-precision adder/subtractor. One SLICE-bit
//            ripple adder is reused for WIDTH/SLICE cycles, least-significant
//            slice first, with the slice carry registered between passes.
// Ports    : clk, reset      - clock, synchronous active-high reset
//            start           - request, taken when ready=1
//            a, b, cin, sub  - operands and mode, captured on accept
//            ready, busy     - controller status
//            done            - one-cycle result-valid pulse
//            s, cout, ovf    - result, final carry (sub: 1 = no borrow),
//                              signed overflow; held until the next DONE
// Revision : 1.0 - initial release
// ============================================================================
module multiword_add_seq
    import multiword_add_seq_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SLICE = SLICE_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);

    localparam int N  = num_slices(WIDTH, SLICE);
    localparam int CW = cnt_width(N);
    localparam logic [CW-1:0] C_LAST = CW'(N - 1);

    if ((SLICE < 1) || ((WIDTH % SLICE) != 0)) begin : g_width_check
        $fatal(1, "multiword_add_seq: WIDTH must be a positive multiple of SLICE");
    end

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;       // already inverted for subtraction
    logic [WIDTH-1:0] r_work;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;

    logic [SLICE-1:0] w_sum;
    logic             w_cout;
    logic [WIDTH-1:0] w_work_next;
    int               w_base;

    assign w_base = int'(r_cnt) * SLICE;

    multiword_add_seq_adder_slice #(
        .SLICE (SLICE)
    ) u_slice (
        .a    (r_a[w_base +: SLICE]),
        .b    (r_b[w_base +: SLICE]),
        .cin  (r_carry),
        .s    (w_sum),
        .cout (w_cout)
    );

    // Working result with the current slice merged in; on the last pass this
    // is the complete sum, so it can be published in the same edge.
    always_comb begin
        w_work_next                   = r_work;
        w_work_next[w_base +: SLICE]  = w_sum;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_work  <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            ready   <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
            s       <= '0;
            cout    <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        r_a     <= a;
                        r_b     <= sub ? ~b : b;
                        r_carry <= sub | cin;
                        r_cnt   <= '0;
                        r_state <= RUN;
                        ready   <= 1'b0;
                        busy    <= 1'b1;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                RUN: begin
                    r_work  <= w_work_next;
                    r_carry <= w_cout;
                    r_cnt   <= r_cnt + CW'(1);
                    if (r_cnt == C_LAST) begin
                        r_state <= DONE;
                        ready   <= 1'b1;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        s       <= w_work_next;
                        cout    <= w_cout;
                        // Operands share a sign but the result does not.
                        ovf     <= (r_a[WIDTH-1] == r_b[WIDTH-1]) &&
                                   (w_work_next[WIDTH-1] != r_a[WIDTH-1]);
                    end
                end
                default: begin
                    r_state <= IDLE;
                    ready   <= 1'b1;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule : multiword_add_seq
`default_nettype wire

// File: tb/tb_multiword_add_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_multiword_add_seq
// Purpose  : Self-checking bench for multiword_add_seq. A cycle-level
//            behavioural model computes results with whole-word arithmetic;
//            a compare process checks every DUT output on every cycle, and
//            directed operations pin the model with literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multiword_add_seq;

    localparam int WIDTH = 16;
    localparam int SLICE = 4;
    localparam int N     = WIDTH / SLICE;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             cin = 1'b0;
    logic             sub = 1'b0;
    logic             ready, busy, done, cout, ovf;
    logic [WIDTH-1:0] s;

    multiword_add_seq #(
        .WIDTH (WIDTH),
        .SLICE (SLICE)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .sub   (sub),
        .ready (ready),
        .busy  (busy),
        .done  (done),
        .s     (s),
        .cout  (cout),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fails  = 0;
    bit chk_en   = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: remaining run cycles, a done flag, and the
    // whole-word result computed at accept time.
    // ------------------------------------------------------------------
    int               m_left = 0;
    bit               m_done = 1'b0;
    logic [WIDTH-1:0] m_s = '0;
    logic             m_cout = 1'b0;
    logic             m_ovf = 1'b0;
    logic [WIDTH-1:0] p_s;
    logic             p_cout, p_ovf;

    task automatic model_result(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_,
                                input logic tcin, input logic tsub,
                                output logic [WIDTH-1:0] rs, output logic rc, output logic ro);
        logic [WIDTH:0]   full;
        logic [WIDTH-1:0] bp;
        bp   = tsub ? ~tb_ : tb_;
        full = {1'b0, ta} + {1'b0, bp} + {{WIDTH{1'b0}}, (tsub ? 1'b1 : tcin)};
        rs   = full[WIDTH-1:0];
        rc   = full[WIDTH];
        ro   = (ta[WIDTH-1] == bp[WIDTH-1]) && (rs[WIDTH-1] != ta[WIDTH-1]);
    endtask

    always @(posedge clk) begin
        if (reset) begin
            m_left = 0; m_done = 1'b0; m_s = '0; m_cout = 1'b0; m_ovf = 1'b0;
        end else if (m_left == 0 && start) begin
            model_result(a, b, cin, sub, p_s, p_cout, p_ovf);
            m_left = N;
            m_done = 1'b0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
                m_done = 1'b1; m_s = p_s; m_cout = p_cout; m_ovf = p_ovf;
            end
        end else begin
            m_done = 1'b0;
        end
    end

    // Compare process: every output, every cycle, mid-period.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("ready", 32'(ready), 32'(m_left == 0));
            chk("busy",  32'(busy),  32'(m_left > 0));
            chk("done",  32'(done),  32'(m_done));
            chk("s",     32'(s),     32'(m_s));
            chk("cout",  32'(cout),  32'(m_cout));
            chk("ovf",   32'(ovf),   32'(m_ovf));
        end
    end

    // ------------------------------------------------------------------
    // Driver helpers; inputs change 2 time units after each rising edge.
    // ------------------------------------------------------------------
    int lat, busy_cnt;

    task automatic next_cyc();
        @(posedge clk); #2;
    endtask

    task automatic idle(input int n);
        repeat (n) next_cyc();
    endtask

    // Issues one operation in the current (ready) cycle and waits until done.
    // noise: pulse start with random operands during RUN.
    task automatic run_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_,
                          input logic tcin, input logic tsub, input bit noise);
        start = 1'b1; a = ta; b = tb_; cin = tcin; sub = tsub;
        next_cyc();
        start = 1'b0;
        a = WIDTH'($urandom); b = WIDTH'($urandom); cin = 1'($urandom); sub = 1'($urandom);
        lat = 1; busy_cnt = 0;
        while (!done && lat < 30) begin
            if (busy) busy_cnt++;
            if (noise && lat == 2) start = 1'b1;
            next_cyc();
            start = 1'b0;
            lat++;
        end
        if (!done) chk("done_timeout", 32'(done), 32'd1);
    endtask

    initial begin
        idle(2);
        reset = 1'b0;
        chk_en = 1'b1;
        // Reset state
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_busy",  32'(busy),  32'd0);
        chk("rst_done",  32'(done),  32'd0);
        chk("rst_s",     32'(s),     32'd0);
        idle(1);

        // 1: carry ripples through every slice
        run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0);
        chk("t1_latency", 32'(lat), 32'(N + 1));
        chk("t1_busy_cycles", 32'(busy_cnt), 32'(N));
        chk("t1_s", 32'(s), 32'h0000);
        chk("t1_cout", 32'(cout), 32'd1);
        chk("t1_ovf", 32'(ovf), 32'd0);
        idle(2);

        // 2: add with carry-in, result held while idle
        run_op(16'h1234, 16'h4321, 1'b1, 1'b0, 1'b0);
        chk("t2_s", 32'(s), 32'h5556);
        chk("t2_cout", 32'(cout), 32'd0);
        idle(4);
        chk("t2_s_hold", 32'(s), 32'h5556);

        // 3: subtraction (cin ignored)
        run_op(16'h0005, 16'h0007, 1'b1, 1'b1, 1'b0);
        chk("t3a_s", 32'(s), 32'hFFFE);
        chk("t3a_cout", 32'(cout), 32'd0);
        chk("t3a_ovf", 32'(ovf), 32'd0);
        idle(1);
        run_op(16'h0007, 16'h0005, 1'b0, 1'b1, 1'b0);
        chk("t3b_s", 32'(s), 32'h0002);
        chk("t3b_cout", 32'(cout), 32'd1);
        idle(1);

        // 4: signed overflow
        run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0);
        chk("t4a_s", 32'(s), 32'h8000);
        chk("t4a_ovf", 32'(ovf), 32'd1);
        idle(1);
        run_op(16'h8000, 16'h0001, 1'b0, 1'b1, 1'b0);
        chk("t4b_s", 32'(s), 32'h7FFF);
        chk("t4b_ovf", 32'(ovf), 32'd1);
        idle(1);

        // 5: start during RUN ignored; back-to-back start in DONE
        run_op(16'h1111, 16'h2222, 1'b0, 1'b0, 1'b1);
        chk("t5a_s", 32'(s), 32'h3333);
        run_op(16'h0F0F, 16'h00F1, 1'b0, 1'b0, 1'b0);
        chk("t5b_latency", 32'(lat), 32'(N + 1));
        chk("t5b_s", 32'(s), 32'h1000);
        idle(2);

        // 6: reset in the second RUN cycle aborts
        start = 1'b1; a = 16'hABCD; b = 16'h1111; cin = 1'b0; sub = 1'b0;
        next_cyc();
        start = 1'b0;
        next_cyc();
        reset = 1'b1;
        next_cyc();
        reset = 1'b0;
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_ready", 32'(ready), 32'd1);
        chk("t6_s", 32'(s), 32'd0);
        chk("t6_done", 32'(done), 32'd0);
        idle(N + 2);
        run_op(16'hABCD, 16'h1111, 1'b0, 1'b0, 1'b0);
        chk("t6_fresh_s", 32'(s), 32'hBCDE);
        idle(1);

        // Random operations, mixing idle gaps, back-to-back and RUN noise
        for (int i = 0; i < 60; i++) begin
            run_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'($urandom),
                   1'($urandom));
            if ($urandom_range(0, 2) != 0) idle($urandom_range(1, 3));
        end
        idle(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule : tb_multiword_add_seq
`default_nettype wire
